// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: pipeline control, instruction-memory port and decode-side handshake.
// Latency: none, this is wiring only; timing is set by the modules on either side.
// Backpressure: imem_ready stalls requests, if_ready stalls decode delivery, hold blocks new requests.
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  // pipeline control
  logic                  hold;
  logic                  branch_valid;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  trap_valid;
  logic [ADDR_WIDTH-1:0] trap_target;

  // instruction memory request / response
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;

  // decode-side buffer
  logic                  if_valid;
  logic [31:0]           if_inst;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_ready;

  // architectural fetch PC
  logic [ADDR_WIDTH-1:0] pc;

  // fetch sequencer side
  modport master (
    input  hold, branch_valid, branch_target, trap_valid, trap_target,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  if_ready,
    output imem_req, imem_addr,
    output if_valid, if_inst, if_pc,
    output pc
  );

  // environment side: pipeline control, memory and decode
  modport slave (
    output hold, branch_valid, branch_target, trap_valid, trap_target,
    output imem_ready, imem_rvalid, imem_rdata,
    output if_ready,
    input  imem_req, imem_addr,
    input  if_valid, if_inst, if_pc,
    input  pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time, buffers the result for decode.
// Latency: request accept -> response -> if_valid next edge; 3 cycles per instruction with zero-wait memory.
// Backpressure: if_ready low holds the decode buffer and blocks the next request; hold gates requests in REQ only.
module fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    INST_BYTES = 4
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic                  drop_q,     drop_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           if_inst_q,  if_inst_d;
  logic [ADDR_WIDTH-1:0] if_pc_q,    if_pc_d;

  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_raw;
  logic [ADDR_WIDTH-1:0] redir_target;
  logic                  req;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] pc_inc;

  // Redirect selection: trap wins over branch; targets are forced word aligned.
  always_comb begin
    redir        = bus.trap_valid | bus.branch_valid;
    redir_raw    = bus.trap_valid ? bus.trap_target : bus.branch_target;
    redir_target = {redir_raw[ADDR_WIDTH-1:2], 2'b00};
  end

  // Request is gated by reset so nothing leaves the block while it is being reset.
  always_comb begin
    req    = reset & (state_q == ST_REQ) & ~bus.hold;
    accept = req & bus.imem_ready;
    pc_inc = pc_q + ADDR_WIDTH'(INST_BYTES);
  end

  // Next-state logic for the fetch FSM and its registered outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      ST_REQ: begin
        // A redirect here only retargets; if the old address was just accepted,
        // its response must be thrown away.
        if (redir) begin
          pc_d = redir_target;
        end
        if (accept) begin
          state_d = ST_WAIT;
          drop_d  = redir;
        end
      end

      ST_WAIT: begin
        if (redir) begin
          // Last redirect wins; the in-flight response is stale either way.
          pc_d = redir_target;
          if (bus.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_valid_d = 1'b1;
            if_inst_d  = bus.imem_rdata;
            if_pc_d    = pc_q;
            state_d    = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        // A redirect takes the target even if decode accepted this cycle;
        // decode is responsible for squashing that instruction.
        if (redir) begin
          pc_d       = redir_target;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (if_valid_q && bus.if_ready) begin
          pc_d       = pc_inc;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_ADDR;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;

  // A pending, unaccepted request must not change address unless redirected.
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (req && !bus.imem_ready && !redir) |=> (pc_q == $past(pc_q)));

  // The decode buffer is only ever full while presenting in OUT.
  a_valid_in_out: assert property (@(posedge clk) disable iff (!reset)
    if_valid_q |-> (state_q == ST_OUT));

endmodule
